// File: rtl/fp_add_top.sv
// fp_add_top: two-stage pipelined IEEE-754 binary32 adder, round-to-nearest-even.
// Subnormal inputs are treated as signed zero and subnormal results flush to +0.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset, clears the whole pipeline
//   a, b   - binary32 operands, sampled every cycle
//   result - registered binary32 sum, valid two rising edges after a/b are sampled
module fp_add_top (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = FRAC_W + 1;   // with hidden bit
  localparam int unsigned EXT_W  = MANT_W + 3;   // mantissa + guard/round/sticky
  localparam int unsigned SUM_W  = EXT_W + 1;    // plus carry-out
  localparam int unsigned LZ_W   = 5;
  localparam int unsigned EW_W   = 10;           // working exponent, two's complement

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

  // Stage-1 to stage-2 payload
  typedef struct packed {
    logic              special;
    logic [31:0]       special_val;
    logic              sign_l;
    logic              sub;
    logic [EXP_W-1:0]  exp_l;
    logic [MANT_W-1:0] mant_l;
    logic [EXT_W-1:0]  mant_s;
  } s1_t;

  s1_t s1_d, s1_q;
  logic [31:0] result_d;

  // Stage-1 operand decode
  logic [EXP_W-1:0]  exp_a, exp_b, exp_s, diff;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic              zero_a, zero_b, nan_a, nan_b, inf_a, inf_b;
  logic [MANT_W-1:0] mant_a, mant_b, mant_s_raw;
  logic [30:0]       mag_a, mag_b;
  logic              a_ge;
  logic [EXT_W-1:0]  ext_s, shifted;
  logic              lost;

  // Stage 1: unpack, classify specials, order by magnitude, align smaller operand
  always_comb begin
    exp_a  = a[30:23];
    exp_b  = b[30:23];
    frac_a = a[22:0];
    frac_b = b[22:0];
    zero_a = (exp_a == '0);
    zero_b = (exp_b == '0);
    nan_a  = (exp_a == EXP_MAX) && (frac_a != '0);
    nan_b  = (exp_b == EXP_MAX) && (frac_b != '0);
    inf_a  = (exp_a == EXP_MAX) && (frac_a == '0);
    inf_b  = (exp_b == EXP_MAX) && (frac_b == '0);
    mant_a = zero_a ? '0 : {1'b1, frac_a};
    mant_b = zero_b ? '0 : {1'b1, frac_b};
    // Subnormals compare as zero so they never become the larger operand
    mag_a  = zero_a ? '0 : a[30:0];
    mag_b  = zero_b ? '0 : b[30:0];
    a_ge   = (mag_a >= mag_b);

    s1_d = '0;
    s1_d.sub = a[31] ^ b[31];

    if (nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31]))) begin
      s1_d.special     = 1'b1;
      s1_d.special_val = QNAN;
    end else if (inf_a) begin
      s1_d.special     = 1'b1;
      s1_d.special_val = {a[31], EXP_MAX, {FRAC_W{1'b0}}};
    end else if (inf_b) begin
      s1_d.special     = 1'b1;
      s1_d.special_val = {b[31], EXP_MAX, {FRAC_W{1'b0}}};
    end

    if (a_ge) begin
      s1_d.sign_l = a[31];
      s1_d.exp_l  = exp_a;
      s1_d.mant_l = mant_a;
      exp_s       = exp_b;
      mant_s_raw  = mant_b;
    end else begin
      s1_d.sign_l = b[31];
      s1_d.exp_l  = exp_b;
      s1_d.mant_l = mant_b;
      exp_s       = exp_a;
      mant_s_raw  = mant_a;
    end

    diff  = s1_d.exp_l - exp_s;
    ext_s = {mant_s_raw, 3'b000};
    // Beyond 26 positions every mantissa bit lands below sticky
    if (diff >= EXP_W'(EXT_W)) begin
      shifted = {{(EXT_W-1){1'b0}}, |mant_s_raw};
      lost    = 1'b0;
    end else begin
      shifted = ext_s >> diff;
      lost    = |(ext_s & ((EXT_W'(1) << diff) - EXT_W'(1)));
    end
    s1_d.mant_s = {shifted[EXT_W-1:1], shifted[0] | lost};
  end

  // Stage-2 datapath
  logic [SUM_W-1:0]  l_ext, s_ext, sum;
  logic [EXT_W-1:0]  norm;
  logic [LZ_W-1:0]   lz;
  logic [EW_W-1:0]   exp_w;
  logic              rnd;
  logic [MANT_W:0]   mant_r;
  logic [MANT_W-1:0] mant_f;
  logic              ovf, unf;

  // Stage 2: add/subtract, normalize, round-to-nearest-even, pack
  always_comb begin
    l_ext = {1'b0, s1_q.mant_l, 3'b000};
    s_ext = {1'b0, s1_q.mant_s};
    sum   = s1_q.sub ? (l_ext - s_ext) : (l_ext + s_ext);

    lz = '0;
    for (int i = 0; i < int'(EXT_W); i++) begin
      if (sum[i]) lz = LZ_W'(int'(EXT_W) - 1 - i);
    end

    if (sum[SUM_W-1]) begin
      // Carry-out: shift right one, folding the dropped bit into sticky
      norm  = {sum[SUM_W-1:2], sum[1] | sum[0]};
      exp_w = EW_W'(s1_q.exp_l) + EW_W'(1);
    end else begin
      norm  = sum[EXT_W-1:0] << lz;
      exp_w = EW_W'(s1_q.exp_l) - EW_W'(lz);
    end

    // Round up above half, or at exactly half when the kept LSB is odd
    rnd    = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[EXT_W-1:3]} + (MANT_W+1)'(rnd);
    if (mant_r[MANT_W]) begin
      mant_f = mant_r[MANT_W:1];
      exp_w  = exp_w + EW_W'(1);
    end else begin
      mant_f = mant_r[MANT_W-1:0];
    end

    ovf = !exp_w[EW_W-1] && (exp_w >= EW_W'(EXP_MAX));
    unf = exp_w[EW_W-1] || (exp_w == '0);

    if (s1_q.special) begin
      result_d = s1_q.special_val;
    end else if (sum == '0) begin
      // Exact cancellation gives +0; same-sign zeros keep their sign
      result_d = {s1_q.sign_l & ~s1_q.sub, 31'd0};
    end else if (ovf) begin
      result_d = {s1_q.sign_l, EXP_MAX, {FRAC_W{1'b0}}};
    end else if (unf) begin
      result_d = '0;
    end else begin
      result_d = {s1_q.sign_l, exp_w[EXP_W-1:0], mant_f[FRAC_W-1:0]};
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      result <= '0;
    end else begin
      s1_q   <= s1_d;
      result <= result_d;
    end
  end

endmodule

// File: tb/tb_fp_add_top.sv
// tb_fp_add_top: directed self-checking bench for fp_add_top.
module tb_fp_add_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  logic [31:0] sa [5];
  logic [31:0] sb [5];
  logic [31:0] se [5];

  always #5 clk = ~clk;

  fp_add_top dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] expv);
    checks++;
    assert (result === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, result, expv);
    end
  endtask

  // Apply one vector and check it two edges later
  task automatic run_vec(input string tag, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] expv);
    @(negedge clk);
    a = va;
    b = vb;
    @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, expv);
  endtask

  initial begin
    rst = 1'b1;
    a   = 32'h3FC0_0000;
    b   = 32'h4020_0000;
    #3;
    check("rst_async", 32'h0000_0000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_clocked", 32'h0000_0000);
    a = 32'h4040_0000;
    @(posedge clk);
    #1;
    check("rst_inputs_ignored", 32'h0000_0000);

    // Release reset with 1.5 + 2.5 on the inputs
    @(negedge clk);
    a   = 32'h3FC0_0000;
    b   = 32'h4020_0000;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("latency_edge1", 32'h0000_0000);
    @(posedge clk);
    #1;
    check("add_1p5_2p5", 32'h4080_0000);

    run_vec("cancel",        32'hC040_0000, 32'h4040_0000, 32'h0000_0000);
    run_vec("tie_even",      32'h4030_0000, 32'h3FA6_6666, 32'h4081_999A);
    run_vec("neg_add1",      32'hBF99_999A, 32'hC000_0000, 32'hC04C_CCCD);
    run_vec("neg_add2",      32'hC0E0_0000, 32'hBF99_999A, 32'hC103_3333);
    run_vec("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    run_vec("overflow_pos",  32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    run_vec("overflow_neg",  32'hFF7F_FFFF, 32'hFF7F_FFFF, 32'hFF80_0000);
    run_vec("nan_in",        32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
    run_vec("inf_finite",    32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000);
    run_vec("inf_same",      32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000);
    run_vec("pz_nz",         32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    run_vec("nz_nz",         32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run_vec("subn_as_zero",  32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000);
    run_vec("subn_zero_sgn", 32'h8040_0000, 32'h8000_0000, 32'h8000_0000);
    run_vec("flush_pos",     32'h00C0_0000, 32'h8080_0000, 32'h0000_0000);
    run_vec("flush_neg",     32'h80C0_0000, 32'h0080_0000, 32'h0000_0000);
    run_vec("sign_larger",   32'h3F80_0000, 32'hC040_0000, 32'hC000_0000);
    run_vec("sub_tie_up",    32'h3F80_0000, 32'hB300_0000, 32'h3F80_0000);
    run_vec("add_tie_down",  32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    run_vec("add_sticky_up", 32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001);
    run_vec("shift_ge27",    32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000);

    // Back-to-back stream, one vector per cycle
    sa[0] = 32'h3FC0_0000; sb[0] = 32'h4020_0000; se[0] = 32'h4080_0000;
    sa[1] = 32'hC040_0000; sb[1] = 32'h4040_0000; se[1] = 32'h0000_0000;
    sa[2] = 32'h4030_0000; sb[2] = 32'h3FA6_6666; se[2] = 32'h4081_999A;
    sa[3] = 32'hBF99_999A; sb[3] = 32'hC000_0000; se[3] = 32'hC04C_CCCD;
    sa[4] = 32'hC0E0_0000; sb[4] = 32'hBF99_999A; se[4] = 32'hC103_3333;
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      if (j < 5) begin
        a = sa[j];
        b = sb[j];
      end
      @(posedge clk);
      #1;
      if (j >= 1) check($sformatf("stream%0d", j - 1), se[j - 1]);
    end

    // Mid-operation reset discards the in-flight vector
    @(negedge clk);
    a = 32'h4030_0000;
    b = 32'h3FA6_6666;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_async", 32'h0000_0000);
    @(posedge clk);
    #1;
    check("midrst_held", 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    a   = 32'h3F80_0000;
    b   = 32'hC040_0000;
    @(posedge clk);
    #1;
    check("midrst_edge1", 32'h0000_0000);
    @(posedge clk);
    #1;
    check("midrst_edge2", 32'hC000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_add_top.md
FP_ADD_TOP -- requirements
Module: fp_add_top

Interface
REQ-001 Parameters: none; all widths fixed at IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a  input  32  operand A, IEEE-754 single-precision.
REQ-005 b  input  32  operand B, IEEE-754 single-precision.
REQ-006 result  output  32  registered IEEE-754 single-precision sum a+b.

Function
REQ-007 The block SHALL compute result = a + b in IEEE-754 binary32, round-to-nearest-ties-to-even.
REQ-008 Pipeline SHALL be 2 stages; a, b sampled at edge N appear on result after edge N+1 (latency 2 edges, throughput 1 per cycle, no handshake).
REQ-009 Stage 1: unpack sign/exponent/mantissa, insert hidden bit, swap so larger magnitude is operand L, right-shift smaller mantissa by exponent difference, keeping guard, round and sticky bits; shifts >= 27 collapse to sticky only.
REQ-010 Stage 2: add mantissas when signs equal, else subtract smaller from larger; normalize (1-bit right shift on carry-out, leading-zero left shift otherwise), round, re-normalize on rounding carry, pack.
REQ-011 Result sign on unequal-sign add SHALL be sign of the larger-magnitude operand.
REQ-012 Exact cancellation (x + -x) SHALL yield +0 (0x00000000).
REQ-013 Subnormal inputs (exponent 0) SHALL be treated as zero of the same sign; subnormal results SHALL flush to +0.
REQ-014 Exponent overflow after rounding SHALL yield signed infinity (0x7F800000 / 0xFF800000).
REQ-015 Any NaN input, or +Inf + -Inf, SHALL yield canonical NaN 0x7FC00000.
REQ-016 Inf + finite SHALL yield that Inf; Inf + same-sign Inf SHALL yield that Inf.
REQ-017 +0 + -0 SHALL yield +0; -0 + -0 SHALL yield -0.

Reset
REQ-018 While rst=1, all pipeline registers and result SHALL be 0x00000000, independent of clk.
REQ-019 Reset assertion mid-operation SHALL discard in-flight values; first valid result appears 2 rising edges after rst deasserts with stable inputs.
REQ-020 Inputs are ignored while rst=1.

Verification
REQ-021 Reset: rst=1, a=0x3FC00000, b=0x40200000 -> result stays 0x00000000 regardless of clocks.
REQ-022 1.5+2.5: a=0x3FC00000, b=0x40200000, rst=0 -> result=0x40800000 after 2 edges.
REQ-023 Cancellation: a=0xC0400000 (-3.0), b=0x40400000 (3.0) -> result=0x00000000.
REQ-024 Tie rounding: a=0x40300000 (2.75), b=0x3FA66666 (1.3) -> result=0x4081999A (ties-to-even).
REQ-025 Negative add: a=0xBF99999A (-1.2), b=0xC0000000 (-2.0) -> result=0xC04CCCCD; a=0xC0E00000 (-7.0), b=0xBF99999A -> result=0xC1033333.
REQ-026 Specials: a=0x7F800000, b=0xFF800000 -> 0x7FC00000; a=0x7F7FFFFF, b=0x7F7FFFFF -> 0x7F800000; back-to-back vectors each cycle -> results stream in order at latency 2.
